// File: rtl/relu_requant_maxpool.sv
// ReLU, shift/saturate requantization and 2x2 stride-2 max pooling over a raster-ordered
// stream of conv results; emits one pooled pixel per completed window.
module relu_requant_maxpool #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IN_W   = 25,
  parameter int unsigned MAP_W  = 4,
  parameter int unsigned MAP_H  = 4,
  parameter int unsigned SHIFT  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_data,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   frame_done
);

  localparam int unsigned ColW     = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int unsigned RowW     = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int unsigned LbDepth  = MAP_W / 2;
  localparam int unsigned LbAw     = (LbDepth > 1) ? $clog2(LbDepth) : 1;
  localparam int unsigned PoolCols = 2 * (MAP_W / 2);
  localparam int unsigned PoolRows = 2 * (MAP_H / 2);
  localparam logic [IN_W-1:0] QMax = {{(IN_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [DATA_W-1:0] held_q;
  logic [DATA_W-1:0] linebuf_q [LbDepth];
  logic              out_valid_q, frame_done_q;
  logic [DATA_W-1:0] out_data_q;

  logic              accept;
  logic [IN_W-1:0]   relu, shifted;
  logic [DATA_W-1:0] q, hmax, lb_rd, pooled;
  logic [LbAw-1:0]   lb_idx;
  logic              col_last, row_last, pool_col, pool_row;
  logic              hold_en, win_h, lb_wr, win_done, last_sample;

  // Reset wins over a coincident sample.
  assign accept = in_valid & ~rst;

  always_comb begin
    relu    = in_data[IN_W-1] ? '0 : in_data;
    shifted = relu >> SHIFT;
    q       = (shifted > QMax) ? QMax[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

  assign col_last = (col_q == ColW'(MAP_W - 1));
  assign row_last = (row_q == RowW'(MAP_H - 1));
  assign pool_col = (32'(col_q) < PoolCols);
  assign pool_row = (32'(row_q) < PoolRows);

  assign lb_idx = LbAw'(col_q >> 1);
  assign lb_rd  = linebuf_q[lb_idx];
  assign hmax   = (held_q > q) ? held_q : q;
  assign pooled = (lb_rd > hmax) ? lb_rd : hmax;

  // Trailing column/row of an odd-sized map falls outside the pooled region and is ignored.
  assign hold_en     = accept & pool_col & ~col_q[0];
  assign win_h       = accept & pool_col & col_q[0];
  assign lb_wr       = win_h & pool_row & ~row_q[0];
  assign win_done    = win_h & pool_row & row_q[0];
  assign last_sample = accept & col_last & row_last;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      held_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= win_done;
      frame_done_q <= last_sample;
      if (hold_en)  held_q     <= q;
      if (win_done) out_data_q <= pooled;
    end
  end

  // Every entry is written on an even row before the odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (lb_wr) linebuf_q[lb_idx] <= hmax;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_requant_maxpool.sv
// Scoreboard bench: three instances (4x4 shift 0, 4x4 shift 2, 3x3 shift 0) share one stimulus
// bus; the selected instance is driven and its pooled outputs are checked in order and timing.
module tb_relu_requant_maxpool;

  localparam int unsigned InW = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic signed [InW-1:0] din = '0;
  int   sel = 0;
  int   cyc = 0;

  logic       ov_a, ov_b, ov_c, fd_a, fd_b, fd_c;
  logic [7:0] od_a, od_b, od_c;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_buf [16];
  int exp_q[$];
  int exp_cyc_q[$];
  int fd_cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  relu_requant_maxpool #(.DATA_W(8), .IN_W(InW), .MAP_W(4), .MAP_H(4), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(vld && sel == 0), .in_data(din),
    .out_valid(ov_a), .out_data(od_a), .frame_done(fd_a)
  );
  relu_requant_maxpool #(.DATA_W(8), .IN_W(InW), .MAP_W(4), .MAP_H(4), .SHIFT(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vld && sel == 1), .in_data(din),
    .out_valid(ov_b), .out_data(od_b), .frame_done(fd_b)
  );
  relu_requant_maxpool #(.DATA_W(8), .IN_W(InW), .MAP_W(3), .MAP_H(3), .SHIFT(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(vld && sel == 2), .in_data(din),
    .out_valid(ov_c), .out_data(od_c), .frame_done(fd_c)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rq(input int x, input int sh);
    int s;
    if (x < 0) return 0;
    s = x >>> sh;
    return (s > 127) ? 127 : s;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Drives the first n samples of frame_buf and pushes the expected pooled values/cycles.
  task automatic send_frame(input int w, input int h, input int sh, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      int r, c, g, m;
      r = k / w;
      c = k % w;
      g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
      vld = 1'b0;
      repeat (g) @(negedge clk);
      vld = 1'b1;
      din = frame_buf[k][InW-1:0];
      if (r % 2 == 1 && c % 2 == 1 && r < 2 * (h / 2) && c < 2 * (w / 2)) begin
        m = max2(max2(rq(frame_buf[(r-1)*w + c-1], sh), rq(frame_buf[(r-1)*w + c], sh)),
                 max2(rq(frame_buf[r*w + c-1], sh), rq(frame_buf[k], sh)));
        exp_q.push_back(m);
        exp_cyc_q.push_back(cyc + 1);
      end
      if (r == h - 1 && c == w - 1) fd_cyc_q.push_back(cyc + 1);
      @(negedge clk);
    end
    vld = 1'b0;
  endtask

  task automatic reset_check();
    check("rst_ov_a", int'(ov_a), 0); check("rst_od_a", int'(od_a), 0);
    check("rst_fd_a", int'(fd_a), 0);
    check("rst_ov_b", int'(ov_b), 0); check("rst_od_b", int'(od_b), 0);
    check("rst_fd_b", int'(fd_b), 0);
    check("rst_ov_c", int'(ov_c), 0); check("rst_od_c", int'(od_c), 0);
    check("rst_fd_c", int'(fd_c), 0);
  endtask

  task automatic fill_ramp(input int n);
    for (int k = 0; k < 16; k++) frame_buf[k] = (k < n) ? k + 1 : 0;
  endtask

  always @(negedge clk) begin
    logic       ov, fd;
    logic [7:0] od;
    case (sel)
      0:       begin ov = ov_a; fd = fd_a; od = od_a; end
      1:       begin ov = ov_b; fd = fd_b; od = od_b; end
      default: begin ov = ov_c; fd = fd_c; od = od_c; end
    endcase
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      check("missed_out", 0, 1);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    if (fd_cyc_q.size() > 0 && fd_cyc_q[0] < cyc) begin
      check("missed_frame_done", 0, 1);
      void'(fd_cyc_q.pop_front());
    end
    if (ov) begin
      if (exp_q.size() == 0) check("unexpected_out", 1, 0);
      else begin
        check("out_data", int'(od), exp_q.pop_front());
        check("out_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
    if (fd) begin
      if (fd_cyc_q.size() == 0) check("unexpected_frame_done", 1, 0);
      else check("frame_done_cycle", cyc, fd_cyc_q.pop_front());
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_check();

    // Ramp 1..16, back-to-back.
    sel = 0;
    fill_ramp(16);
    send_frame(4, 4, 0, 16, 0);
    repeat (3) @(negedge clk);

    // Saturation with one odd sample per window, then 12..15 per window.
    sel = 1;
    for (int k = 0; k < 16; k++) begin
      int wi, pos;
      wi  = (k / 8) * 2 + (k % 4) / 2;
      pos = ((k / 4) % 2) * 2 + (k % 2);
      frame_buf[k] = 1000;
      if (pos == wi) frame_buf[k] = (wi == 0) ? -500 : (wi == 1) ? 40 : (wi == 2) ? 3 : -1;
    end
    send_frame(4, 4, 2, 16, 0);
    for (int k = 0; k < 16; k++) frame_buf[k] = 12 + ((k / 4) % 2) * 2 + (k % 2);
    send_frame(4, 4, 2, 16, 0);
    repeat (3) @(negedge clk);

    // All negative.
    sel = 0;
    for (int k = 0; k < 16; k++) frame_buf[k] = (k % 2 == 1) ? -1 : -(1 << 24);
    send_frame(4, 4, 0, 16, 0);
    repeat (3) @(negedge clk);

    // Ramp with random idle gaps.
    fill_ramp(16);
    send_frame(4, 4, 0, 16, 3);
    repeat (3) @(negedge clk);

    // Abort after 9 samples with a sample coinciding with reset, then a clean frame.
    send_frame(4, 4, 0, 9, 0);
    rst = 1'b1;
    vld = 1'b1;
    din = 25'sd100;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_od_a", int'(od_a), 0);
    send_frame(4, 4, 0, 16, 0);
    repeat (3) @(negedge clk);

    // 3x3 map, two frames back-to-back.
    sel = 2;
    fill_ramp(9);
    send_frame(3, 3, 0, 9, 0);
    send_frame(3, 3, 0, 9, 1);
    repeat (5) @(negedge clk);

    check("scoreboard_left", exp_q.size(), 0);
    check("frame_done_left", fd_cyc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
